// File: rtl/pwr_rst_seq.sv
// -----------------------------------------------------------------------------
// pwr_rst_seq
//
// Power-on reset sequencer. Holds CH_NUM active-low reset outputs low until the
// PLL reports lock and a power-on delay has elapsed. It then releases the
// channels one at a time, bit 0 first, with a fixed gap between channels. The
// whole sequence restarts on PLL lock loss or on a soft reset request.
//
// Optional feature (macro PWR_RST_WDOG_EN):
//   Adds the wdog_kick input and a watchdog. While in RUN, the watchdog counts
//   cycles since the last kick. When it reaches WDOG_TIMEOUT, the sequence
//   restarts as if a soft reset request had pulsed once. Without the macro
//   there is no wdog_kick port, no watchdog logic, and WDOG_TIMEOUT is ignored.
//
// Parameters:
//   MAIN_CLOCK_PERIOD  clk period in ns
//   PWR_RST_DELAY      power-on delay after lock, ns (truncated to whole cycles)
//   CH_STEP_DELAY      gap between channel releases, ns (truncated to cycles)
//   CH_NUM             number of reset outputs, 1..16
//   WDOG_TIMEOUT       watchdog timeout in clk cycles (watchdog builds only)
//
// Ports:
//   clk           in   1       main clock
//   rst           in   1       synchronous, active-low reset
//   locked        in   1       PLL lock, asynchronous (2-flop synchronised)
//   soft_rst_req  in   1       soft reset request, asynchronous level (2-flop)
//   wdog_kick     in   1       watchdog kick, clk-synchronous (watchdog only)
//   rst_out       out  CH_NUM  per-channel active-low reset, bit 0 first
//   done          out  1       all channels released, sequencer in RUN
// -----------------------------------------------------------------------------
module pwr_rst_seq #(
   parameter int unsigned MAIN_CLOCK_PERIOD = 7,
   parameter int unsigned PWR_RST_DELAY     = 100000000,
   parameter int unsigned CH_STEP_DELAY     = 1000,
   parameter int unsigned CH_NUM            = 4,
   parameter int unsigned WDOG_TIMEOUT      = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              locked,
   input  logic              soft_rst_req,
`ifdef PWR_RST_WDOG_EN
   input  logic              wdog_kick,
`endif
   output logic [CH_NUM-1:0] rst_out,
   output logic              done
);

   localparam logic [31:0] DELAY_CYCLES = 32'(PWR_RST_DELAY / MAIN_CLOCK_PERIOD);
   localparam logic [31:0] STEP_CYCLES  = 32'(CH_STEP_DELAY / MAIN_CLOCK_PERIOD);
   // Terminal counts. They wrap when the cycle count is zero, but the
   // zero-length cases are decoded separately and never compare against them.
   localparam logic [31:0] DELAY_LAST   = DELAY_CYCLES - 32'd1;
   localparam logic [31:0] STEP_LAST    = STEP_CYCLES - 32'd1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      PWR_DELAY = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [CH_NUM-1:0]   rst_out_q, rst_out_d;
   logic                done_q, done_d;

   logic                locked_meta_q, locked_s_q;
   logic                req_meta_q, req_s_q;

   logic                wdog_to;
   logic                active;
   logic                lock_lost;
   logic                restart;
   logic                start_rel;

   // Releases the next channel. Released channels stay released, so the
   // release pattern is a thermometer code that grows upwards from bit 0.
   function automatic logic [CH_NUM-1:0] shift_in_one(input logic [CH_NUM-1:0] v);
      logic [CH_NUM-1:0] r;
      r    = '0;
      r[0] = 1'b1;
      for (int i = 1; i < int'(CH_NUM); i++) begin
         r[i] = v[i-1];
      end
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // Input synchronisers (locked, soft_rst_req)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         locked_meta_q <= 1'b0;
         locked_s_q    <= 1'b0;
         req_meta_q    <= 1'b0;
         req_s_q       <= 1'b0;
      end else begin
         locked_meta_q <= locked;
         locked_s_q    <= locked_meta_q;
         req_meta_q    <= soft_rst_req;
         req_s_q       <= req_meta_q;
      end
   end

   // -------------------------------------------------------------------------
   // Watchdog
   // -------------------------------------------------------------------------
`ifdef PWR_RST_WDOG_EN
   localparam logic [31:0] WDOG_LAST = 32'(WDOG_TIMEOUT) - 32'd1;

   logic [31:0] wdog_q, wdog_d;

   // Fires on the cycle that would complete WDOG_TIMEOUT cycles without a kick.
   assign wdog_to = (state_q == RUN) && !wdog_kick && (wdog_q == WDOG_LAST);

   always_comb begin
      wdog_d = '0;
      // Stays at zero outside RUN, including on the edge that leaves RUN.
      if ((state_q == RUN) && (state_d == RUN) && !wdog_kick) begin
         wdog_d = wdog_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_to = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Sequencer next-state logic
   // -------------------------------------------------------------------------
   assign active    = (state_q == PWR_DELAY) || (state_q == RELEASE) || (state_q == RUN);
   // Lock loss outranks a soft request, which outranks a watchdog timeout.
   assign lock_lost = active && !locked_s_q;
   assign restart   = active && (req_s_q || wdog_to);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rst_out_d = rst_out_q;
      done_d    = done_q;
      start_rel = 1'b0;

      if (lock_lost) begin
         state_d   = WAIT_LOCK;
         cnt_d     = '0;
         rst_out_d = '0;
         done_d    = 1'b0;
      end else if (restart) begin
         // Re-entering PWR_DELAY with cnt cleared. While the request stays
         // high this branch is taken every cycle, so cnt is held at zero.
         state_d   = PWR_DELAY;
         cnt_d     = '0;
         rst_out_d = '0;
         done_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = WAIT_LOCK;
               cnt_d     = '0;
               rst_out_d = '0;
               done_d    = 1'b0;
            end

            WAIT_LOCK: begin
               cnt_d     = '0;
               rst_out_d = '0;
               done_d    = 1'b0;
               if (locked_s_q) begin
                  if (DELAY_CYCLES == 32'd0) begin
                     start_rel = 1'b1;
                  end else begin
                     state_d = PWR_DELAY;
                  end
               end
            end

            PWR_DELAY: begin
               if ((DELAY_CYCLES == 32'd0) || (cnt_q == DELAY_LAST)) begin
                  start_rel = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end

            RELEASE: begin
               if (cnt_q == STEP_LAST) begin
                  cnt_d     = '0;
                  rst_out_d = shift_in_one(rst_out_q);
                  if (rst_out_d[CH_NUM-1]) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end

            RUN: begin
               cnt_d = '0;
            end

            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               rst_out_d = '0;
               done_d    = 1'b0;
            end
         endcase

         // Release channel 0. With a single channel or a zero step, every
         // channel is released at once and the sequence completes here.
         if (start_rel) begin
            cnt_d = '0;
            if ((CH_NUM == 1) || (STEP_CYCLES == 32'd0)) begin
               rst_out_d = '1;
               done_d    = 1'b1;
               state_d   = RUN;
            end else begin
               rst_out_d    = '0;
               rst_out_d[0] = 1'b1;
               state_d      = RELEASE;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer state and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rst_out_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
      end
   end

   assign rst_out = rst_out_q;
   assign done    = done_q;

endmodule

// File: tb/tb_pwr_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pwr_rst_seq
//
// Directed bench for pwr_rst_seq with MAIN_CLOCK_PERIOD=10, PWR_RST_DELAY=200
// (20 cycles), CH_STEP_DELAY=50 (5 cycles), CH_NUM=3, WDOG_TIMEOUT=50.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point. Latencies are counted in rising edges from the step that set up the
// stimulus.
// -----------------------------------------------------------------------------
module tb_pwr_rst_seq;

   logic       clk;
   logic       rst;
   logic       locked;
   logic       soft_rst_req;
   logic [2:0] rst_out;
   logic       done;
`ifdef PWR_RST_WDOG_EN
   logic       wdog_kick;
`endif

   int n_cmp;
   int n_err;
   int n;

   pwr_rst_seq #(
      .MAIN_CLOCK_PERIOD (10),
      .PWR_RST_DELAY     (200),
      .CH_STEP_DELAY     (50),
      .CH_NUM            (3),
      .WDOG_TIMEOUT      (50)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .locked       (locked),
      .soft_rst_req (soft_rst_req),
`ifdef PWR_RST_WDOG_EN
      .wdog_kick    (wdog_kick),
`endif
      .rst_out      (rst_out),
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts edges until rst_out equals target, giving up after limit edges.
   task automatic wait_out(input logic [2:0] target, input int limit, output int edges);
      edges = 0;
      while ((rst_out !== target) && (edges < limit)) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst          = 1'b0;
      locked       = 1'b1;
      soft_rst_req = 1'b0;
`ifdef PWR_RST_WDOG_EN
      wdog_kick    = 1'b0;
`endif

      // 1: reset with lock present, then full sequence 2 sync + 1 + 20 / 5 / 5
      tick(1);
      chk("reset_rst_out_e1", rst_out, 3'b000);
      chk("reset_done_e1", done, 1'b0);
      tick(4);
      chk("reset_rst_out_e5", rst_out, 3'b000);
      chk("reset_done_e5", done, 1'b0);
      rst = 1'b1;
      wait_out(3'b001, 100, n);
      chk("t1_ch0_latency", n, 23);
      chk("t1_ch0_done", done, 1'b0);
      wait_out(3'b011, 50, n);
      chk("t1_ch1_step", n, 5);
      chk("t1_ch1_done", done, 1'b0);
      wait_out(3'b111, 50, n);
      chk("t1_ch2_step", n, 5);
      chk("t1_run_done", done, 1'b1);

      // 3: one-cycle lock drop in RUN, outputs fall on the third edge
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      wait_out(3'b000, 10, n);
      chk("t3_drop_latency", n, 2);
      chk("t3_drop_done", done, 1'b0);
      wait_out(3'b001, 100, n);
      chk("t3_ch0_latency", n, 21);
      wait_out(3'b011, 50, n);
      chk("t3_ch1_step", n, 5);
      wait_out(3'b111, 50, n);
      chk("t3_ch2_step", n, 5);
      chk("t3_run_done", done, 1'b1);

      // 2: lock absent for 100 cycles after reset release
      rst    = 1'b0;
      locked = 1'b0;
      tick(3);
      chk("t2_reset_rst_out", rst_out, 3'b000);
      chk("t2_reset_done", done, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(25);
         chk("t2_nolock_rst_out", rst_out, 3'b000);
         chk("t2_nolock_done", done, 1'b0);
      end
      locked = 1'b1;
      wait_out(3'b001, 100, n);
      chk("t2_ch0_latency", n, 23);

      // 4: soft request for 10 cycles while in RELEASE after channel 0
      soft_rst_req = 1'b1;
      wait_out(3'b000, 10, n);
      chk("t4_req_latency", n, 3);
      chk("t4_req_done", done, 1'b0);
      tick(7);
      chk("t4_req_held", rst_out, 3'b000);
      soft_rst_req = 1'b0;
      wait_out(3'b001, 100, n);
      chk("t4_ch0_latency", n, 22);
      wait_out(3'b011, 50, n);
      chk("t4_ch1_step", n, 5);
      wait_out(3'b111, 50, n);
      chk("t4_ch2_step", n, 5);
      chk("t4_run_done", done, 1'b1);

      // 5: reset asserted mid-RELEASE, then restart from WAIT_LOCK
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      wait_out(3'b000, 10, n);
      chk("t5_drop_latency", n, 2);
      wait_out(3'b001, 100, n);
      chk("t5_ch0_latency", n, 21);
      wait_out(3'b011, 50, n);
      chk("t5_ch1_step", n, 5);
      rst = 1'b0;
      tick(1);
      chk("t5_rst_rst_out", rst_out, 3'b000);
      chk("t5_rst_done", done, 1'b0);
      rst = 1'b1;
      wait_out(3'b001, 100, n);
      chk("t5_ch0_restart", n, 23);
      wait_out(3'b011, 50, n);
      chk("t5_ch1_restart", n, 5);
      wait_out(3'b111, 50, n);
      chk("t5_ch2_restart", n, 5);
      chk("t5_run_done", done, 1'b1);

`ifdef PWR_RST_WDOG_EN
      // 6: no kick for 50 cycles in RUN restarts the sequence, kicks hold RUN
      wait_out(3'b000, 100, n);
      chk("t6_wdog_timeout", n, 50);
      chk("t6_wdog_done", done, 1'b0);
      wait_out(3'b001, 100, n);
      chk("t6_ch0_latency", n, 20);
      wait_out(3'b011, 50, n);
      chk("t6_ch1_step", n, 5);
      wait_out(3'b111, 50, n);
      chk("t6_ch2_step", n, 5);
      for (int i = 0; i < 3; i++) begin
         tick(39);
         wdog_kick = 1'b1;
         tick(1);
         wdog_kick = 1'b0;
         chk("t6_kick_rst_out", rst_out, 3'b111);
         chk("t6_kick_done", done, 1'b1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
